v_pixel_packer_4ppc: RTL and testbench

Upstream width converter for the 4ppc video path: accepts a 1-pixel-per-clock AXI4-Stream video stream and packs four consecutive pixels of a line into one 4ppc beat for the 4ppc downscaler. Line ends (tlast) flush partial beats with tkeep marking the valid lanes. Start-of-frame (tuser) always lands in lane 0. Sits between the 1ppc source (TPG / sensor front end) and the 4ppc resizer.

---
 rtl/v_pixel_packer_4ppc_pkg.sv | 16 +
 rtl/v_pixel_packer_4ppc.sv | 116 +++++++++++
 tb/tb_v_pixel_packer_4ppc.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/v_pixel_packer_4ppc_pkg.sv
// rtl/v_pixel_packer_4ppc_pkg.sv - shared video constants for the 4ppc path
package v_pixel_packer_4ppc_pkg;

  localparam int PIXEL_WIDTH_DEFAULT = 24;
  localparam int PPC_FIXED           = 4;

  localparam int PAD_ZERO      = 0;
  localparam int PAD_REPLICATE = 1;

  typedef logic [1:0] lane_t;

  function automatic int pixel_bytes(input int pw);
    return pw / 8;
  endfunction

endpackage

// File: rtl/v_pixel_packer_4ppc.sv
// rtl/v_pixel_packer_4ppc.sv - packs a 1ppc AXI4-Stream video line into 4ppc beats
module v_pixel_packer_4ppc
  import v_pixel_packer_4ppc_pkg::*;
#(
  parameter int PIEXL_WIDTH  = PIXEL_WIDTH_DEFAULT,
  parameter int PPC          = PPC_FIXED,
  parameter int M_AXIS_WIDTH = PIEXL_WIDTH * PPC,
  parameter int M_AXIS_BYTES = M_AXIS_WIDTH / 8,
  parameter int PAD_MODE     = PAD_ZERO
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [PIEXL_WIDTH-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic [M_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [M_AXIS_BYTES-1:0] m_axis_tkeep,
  output logic [M_AXIS_BYTES-1:0] m_axis_tstrb,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tid,
  output logic                    m_axis_tdest,
  output logic                    sof_resync
);

  localparam int BPL = pixel_bytes(PIEXL_WIDTH);

  lane_t                  lane;
  logic [PIEXL_WIDTH-1:0] acc [PPC-1];
  logic                   acc_sof;

  logic                    accept;
  logic                    resync;
  logic                    complete;
  lane_t                   eff_lane;
  logic [PIEXL_WIDTH-1:0]  pad_px;
  logic [M_AXIS_WIDTH-1:0] beat_data;
  logic [M_AXIS_BYTES-1:0] beat_keep;
  logic                    beat_sof;

  // The output register is the only buffer, so readiness follows it alone.
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tstrb  = m_axis_tkeep;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;

  always_comb begin
    resync    = accept & s_axis_tuser & (lane != 2'd0);
    eff_lane  = resync ? 2'd0 : lane;
    complete  = accept & ((eff_lane == 2'd3) | s_axis_tlast);
    pad_px    = (PAD_MODE == PAD_REPLICATE) ? s_axis_tdata : '0;
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < PPC - 1; k++) begin
      if (k < int'(eff_lane))
        beat_data[k*PIEXL_WIDTH +: PIEXL_WIDTH] = acc[k];
      else if (k == int'(eff_lane))
        beat_data[k*PIEXL_WIDTH +: PIEXL_WIDTH] = s_axis_tdata;
      else
        beat_data[k*PIEXL_WIDTH +: PIEXL_WIDTH] = pad_px;
    end
    beat_data[(PPC-1)*PIEXL_WIDTH +: PIEXL_WIDTH] =
      (eff_lane == 2'd3) ? s_axis_tdata : pad_px;
    for (int k = 0; k < PPC; k++)
      beat_keep[k*BPL +: BPL] = {BPL{k <= int'(eff_lane)}};
    beat_sof  = (eff_lane == 2'd0) ? s_axis_tuser : acc_sof;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane          <= 2'd0;
      acc_sof       <= 1'b0;
      for (int i = 0; i < PPC - 1; i++) acc[i] <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sof_resync    <= 1'b0;
    end else begin
      sof_resync <= resync;
      if (accept) begin
        // A misplaced SOF drops the partial beat and restarts at lane 0.
        if (resync)
          for (int i = 0; i < PPC - 1; i++) acc[i] <= '0;
        if (complete) begin
          lane <= 2'd0;
        end else begin
          case (eff_lane)
            2'd0:    acc[0] <= s_axis_tdata;
            2'd1:    acc[1] <= s_axis_tdata;
            2'd2:    acc[2] <= s_axis_tdata;
            default: ;
          endcase
          if (eff_lane == 2'd0) acc_sof <= s_axis_tuser;
          lane <= eff_lane + 2'd1;
        end
      end
      if (complete) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tkeep  <= beat_keep;
        m_axis_tuser  <= beat_sof;
        m_axis_tlast  <= s_axis_tlast;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_v_pixel_packer_4ppc.sv
// tb/tb_v_pixel_packer_4ppc.sv - randomized self-checking bench for v_pixel_packer_4ppc
module tb_v_pixel_packer_4ppc;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast;
  logic        m_tready;

  logic        s_tready0, s_tready1;
  logic [95:0] m_tdata0, m_tdata1;
  logic        m_tvalid0, m_tvalid1;
  logic [11:0] m_tkeep0, m_tkeep1, m_tstrb0, m_tstrb1;
  logic        m_tuser0, m_tuser1, m_tlast0, m_tlast1;
  logic        m_tid0, m_tid1, m_tdest0, m_tdest1;
  logic        resync0, resync1;

  int n_cmp = 0;
  int n_err = 0;
  int rmode = 0;

  always #5 aclk = ~aclk;

  v_pixel_packer_4ppc #(.PAD_MODE(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
    .m_axis_tkeep(m_tkeep0), .m_axis_tstrb(m_tstrb0), .m_axis_tuser(m_tuser0),
    .m_axis_tlast(m_tlast0), .m_axis_tid(m_tid0), .m_axis_tdest(m_tdest0),
    .sof_resync(resync0)
  );

  v_pixel_packer_4ppc #(.PAD_MODE(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
    .m_axis_tkeep(m_tkeep1), .m_axis_tstrb(m_tstrb1), .m_axis_tuser(m_tuser1),
    .m_axis_tlast(m_tlast1), .m_axis_tid(m_tid1), .m_axis_tdest(m_tdest1),
    .sof_resync(resync1)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixels of the current group in arrival order.
  typedef struct {
    logic [95:0] d0;
    logic [95:0] d1;
    logic [11:0] keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [23:0] cur[$];
  logic        cur_sof;
  logic        exp_resync;
  logic        prev_acc, prev_hs;
  logic [23:0] prev_d;
  logic        prev_u, prev_l;

  task automatic model_accept(input logic [23:0] d, input logic u, input logic l);
    beat_t b;
    int    n;
    if (u && cur.size() != 0) begin
      cur.delete();
      exp_resync = 1'b1;
    end
    if (cur.size() == 0) cur_sof = u;
    cur.push_back(d);
    if (cur.size() == 4 || l) begin
      n      = cur.size();
      b.d0   = '0;
      b.d1   = '0;
      for (int i = 0; i < 4; i++) begin
        b.d0[i*24 +: 24] = (i < n) ? cur[i] : 24'h0;
        b.d1[i*24 +: 24] = (i < n) ? cur[i] : cur[n-1];
      end
      b.keep = 12'((1 << (3 * n)) - 1);
      b.user = cur_sof;
      b.last = l;
      exp_q.push_back(b);
      cur.delete();
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      cur.delete();
      exp_q.delete();
      prev_acc   = 1'b0;
      prev_hs    = 1'b0;
      exp_resync = 1'b0;
      check("rst_tvalid", {m_tvalid0, m_tvalid1}, 2'b00);
      check("rst_tdata", m_tdata0 | m_tdata1, 96'h0);
      check("rst_tkeep", {m_tkeep0, m_tstrb0}, 24'h0);
      check("rst_flags", {m_tuser0, m_tlast0, resync0, m_tid0, m_tdest0}, 5'h0);
      check("rst_s_tready", s_tready0, 1'b1);
    end else begin
      exp_resync = 1'b0;
      if (prev_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (prev_acc) model_accept(prev_d, prev_u, prev_l);
      check("tvalid0", m_tvalid0, exp_q.size() != 0);
      check("tvalid1", m_tvalid1, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("tdata_pad0", m_tdata0, exp_q[0].d0);
        check("tdata_pad1", m_tdata1, exp_q[0].d1);
        check("tkeep", m_tkeep0, exp_q[0].keep);
        check("tstrb", m_tstrb1, exp_q[0].keep);
        check("tuser", m_tuser0, exp_q[0].user);
        check("tlast", m_tlast1, exp_q[0].last);
      end
      check("sof_resync", {resync0, resync1}, {2{exp_resync}});
      check("s_tready", {s_tready0, s_tready1}, {2{exp_q.size() == 0 || m_tready}});
      check("tid_tdest", {m_tid0, m_tdest0, m_tid1, m_tdest1}, 4'h0);
      prev_hs  = m_tvalid0 & m_tready;
      prev_acc = s_tvalid & s_tready0;
      prev_d   = s_tdata;
      prev_u   = s_tuser;
      prev_l   = s_tlast;
    end
  end

  always @(posedge aclk) begin
    #1;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b0;
    endcase
  end

  task automatic send_px(input logic [23:0] d, input logic u, input logic l);
    int t = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready0 && t < 200) begin
      t++;
      @(negedge aclk);
    end
    if (!s_tready0) check("px_timeout", s_tready0, 1'b1);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_line(input int n, input logic sof, input logic [23:0] base);
    for (int i = 0; i < n; i++)
      send_px(base + 24'(i), sof && i == 0, i == n - 1);
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    idle(3);
    aresetn = 1'b1;
    idle(1);

    send_line(8, 1'b1, 24'h000001);
    idle(3);
    send_line(6, 1'b0, 24'h000001);
    idle(3);

    rmode = 1;
    send_line(16, 1'b0, 24'h000100);
    idle(6);
    rmode = 0;
    idle(2);

    send_px(24'h000201, 1'b0, 1'b0);
    send_px(24'h000202, 1'b0, 1'b0);
    send_px(24'h000203, 1'b1, 1'b0);
    send_px(24'h000204, 1'b0, 1'b0);
    send_px(24'h000205, 1'b0, 1'b0);
    send_px(24'h000206, 1'b0, 1'b1);
    idle(3);

    send_px(24'h000501, 1'b1, 1'b1);
    idle(3);

    send_px(24'h000301, 1'b0, 1'b0);
    send_px(24'h000302, 1'b0, 1'b0);
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", {m_tvalid0, m_tvalid1, resync0}, 3'b000);
    check("async_rst_tdata", m_tdata0 | m_tdata1, 96'h0);
    idle(2);
    aresetn = 1'b1;
    idle(1);
    send_line(4, 1'b1, 24'h000311);
    idle(3);

    rmode = 3;
    idle(1);
    send_line(4, 1'b0, 24'h000401);
    s_tdata  = 24'h000405;
    s_tuser  = 1'b0;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      check("stall_s_tready", s_tready0, 1'b0);
    end
    rmode = 0;
    send_px(24'h000405, 1'b0, 1'b1);
    idle(3);

    rmode = 2;
    for (int ln = 0; ln < 40; ln++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        logic u;
        u = (i == 0) ? (ln % 4 == 0) : ($urandom_range(0, 15) == 0);
        send_px(24'($urandom), u, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end

    rmode = 0;
    idle(10);
    check("drain_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
